dma_desc_queue: RTL and testbench

// - Descriptor queue between the DMA CSR block and the DMA transfer engine. Captures each single-cycle
//   CSR write strobe (src/dst/len/last) into a DEPTH-entry FIFO and reports fifo-full back to STATREG[0].
// - Issues descriptors to the engine one at a time over valid/ready, tracks the in-flight one, and

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_sync_fifo.sv | 74 +++++++
 rtl/dma_desc_queue.sv | 113 +++++++++++
 tb/tb_dma_desc_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor queue.
package dma_pkg;

  localparam int DMA_DESC_DEPTH = 8;
  localparam int DMA_ADDR_W     = 32;
  localparam int DMA_LEN_W      = 16;

  typedef logic [DMA_ADDR_W-1:0] desc_addr_t;
  typedef logic [DMA_LEN_W-1:0]  desc_num_t;

  // One queued descriptor as captured from the CSR write strobe.
  typedef struct packed {
    desc_addr_t src;
    desc_addr_t dst;
    desc_num_t  len;
    logic       last;
  } desc_entry_t;

  typedef enum logic {
    DQ_IDLE,
    DQ_BUSY
  } dma_q_state_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with synchronous flush, registered full flag and
// head-of-queue read data (no write-to-read bypass).
module dma_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            push_ok;
  logic            pop_ok;

  // Full is judged on the flag as it stood at the start of the cycle, so a
  // same-cycle pop never makes room for a push into a full queue.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointer, count and full-flag bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; pointers and count alone define what is valid.
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor queue between the DMA CSR block and the transfer engine:
// buffers descriptors, issues them one at a time, tracks the in-flight
// descriptor and raises the scheduler interrupt on last-done or error.
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter int DEPTH = DMA_DESC_DEPTH
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dma_ctrl_write_i,
  input  logic       dma_ctrl_last_i,
  input  logic       dma_clear_irq_i,
  input  desc_addr_t dma_desc_src_i,
  input  desc_addr_t dma_desc_dst_i,
  input  desc_num_t  dma_desc_len_i,
  output logic       dma_csr_fifo_full_o,
  output logic       dma_push_drop_o,
  output logic       desc_valid_o,
  input  logic       desc_ready_i,
  output desc_addr_t desc_src_o,
  output desc_addr_t desc_dst_o,
  output desc_num_t  desc_len_o,
  output logic       desc_last_o,
  input  logic       desc_done_i,
  input  logic       dma_error_i,
  output logic       dma_busy_o,
  output logic       dma_irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  dma_q_state_e  state;
  logic          last_q;
  desc_entry_t   push_entry;
  desc_entry_t   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          issue;
  logic          irq_set;

  assign push_entry = '{src:  dma_desc_src_i,
                        dst:  dma_desc_dst_i,
                        len:  dma_desc_len_i,
                        last: dma_ctrl_last_i};

  // Head is offered only while no descriptor is in flight.
  assign desc_valid_o = (state == DQ_IDLE) && !fifo_empty;
  assign issue        = desc_valid_o && desc_ready_i && !dma_error_i;
  assign irq_set      = (state == DQ_BUSY) && desc_done_i && last_q;

  assign desc_src_o  = desc_valid_o ? head.src  : '0;
  assign desc_dst_o  = desc_valid_o ? head.dst  : '0;
  assign desc_len_o  = desc_valid_o ? head.len  : '0;
  assign desc_last_o = desc_valid_o ? head.last : 1'b0;

  assign dma_busy_o          = (state == DQ_BUSY);
  assign dma_csr_fifo_full_o = fifo_full;

  dma_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (desc_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (dma_ctrl_write_i && !dma_error_i),
    .pop   (issue),
    .flush (dma_error_i),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Issue/complete state machine with drop pulse and level interrupt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= DQ_IDLE;
      last_q          <= 1'b0;
      dma_irq_o       <= 1'b0;
      dma_push_drop_o <= 1'b0;
    end else begin
      dma_push_drop_o <= dma_ctrl_write_i && (fifo_full || dma_error_i);
      if (dma_error_i) begin
        state     <= DQ_IDLE;
        last_q    <= 1'b0;
        dma_irq_o <= 1'b1;
      end else begin
        case (state)
          DQ_IDLE: begin
            if (issue) begin
              state  <= DQ_BUSY;
              last_q <= head.last;
            end
          end
          DQ_BUSY: begin
            if (desc_done_i) state <= DQ_IDLE;
          end
          default: state <= DQ_IDLE;
        endcase
        dma_irq_o <= irq_set || (dma_irq_o && !dma_clear_irq_i);
      end
    end
  end

  // Occupancy can never exceed the queue depth.
  always_ff @(posedge clk) begin
    if (rstn) assert (fifo_count <= CW'(DEPTH));
  end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Bench for dma_desc_queue: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_dma_desc_queue;
  import dma_pkg::*;

  localparam int DEPTH = DMA_DESC_DEPTH;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr, lst, clr, rdy, done, err;
  desc_addr_t src, dst;
  desc_num_t  len;

  logic       full_o, drop_o, valid_o, last_o, busy_o, irq_o;
  desc_addr_t src_o, dst_o;
  desc_num_t  len_o;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dma_desc_queue #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .dma_ctrl_write_i    (wr),
    .dma_ctrl_last_i     (lst),
    .dma_clear_irq_i     (clr),
    .dma_desc_src_i      (src),
    .dma_desc_dst_i      (dst),
    .dma_desc_len_i      (len),
    .dma_csr_fifo_full_o (full_o),
    .dma_push_drop_o     (drop_o),
    .desc_valid_o        (valid_o),
    .desc_ready_i        (rdy),
    .desc_src_o          (src_o),
    .desc_dst_o          (dst_o),
    .desc_len_o          (len_o),
    .desc_last_o         (last_o),
    .desc_done_i         (done),
    .dma_error_i         (err),
    .dma_busy_o          (busy_o),
    .dma_irq_o           (irq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the queue contents, whether an engine transfer is
  // outstanding, that transfer's last flag, the interrupt level, drop pulse.
  desc_entry_t mq[$];
  bit m_busy, m_last, m_irq, m_drop;

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_last = 1'b0;
    m_irq  = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_step();
    bit          offered, was_full, set;
    desc_entry_t e;
    offered  = !m_busy && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    if (err) begin
      mq.delete();
      m_busy = 1'b0;
      m_last = 1'b0;
      m_irq  = 1'b1;
      m_drop = wr;
    end else begin
      set    = 1'b0;
      m_drop = wr && was_full;
      if (offered && rdy) begin
        m_last = mq[0].last;
        mq.delete(0);
        m_busy = 1'b1;
      end else if (m_busy && done) begin
        m_busy = 1'b0;
        set    = m_last;
      end
      if (wr && !was_full) begin
        e.src = src; e.dst = dst; e.len = len; e.last = lst;
        mq.push_back(e);
      end
      m_irq = set || (m_irq && !clr);
    end
  endtask

  task automatic cmp();
    bit          exp_valid;
    desc_entry_t h;
    exp_valid = !m_busy && (mq.size() > 0);
    h = exp_valid ? mq[0] : '0;
    check("valid", valid_o, exp_valid);
    check("src",   src_o,   h.src);
    check("dst",   dst_o,   h.dst);
    check("len",   len_o,   h.len);
    check("last",  last_o,  h.last);
    check("full",  full_o,  mq.size() == DEPTH);
    check("busy",  busy_o,  m_busy);
    check("irq",   irq_o,   m_irq);
    check("drop",  drop_o,  m_drop);
  endtask

  // Single compare point, half a cycle away from the active edge.
  always @(negedge clk) if (chk_en && rstn) cmp();

  // One clock: DUT and model both consume the current inputs, then strobes drop.
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    #1;
    wr = 1'b0; lst = 1'b0; clr = 1'b0; done = 1'b0; err = 1'b0;
  endtask

  task automatic push(input desc_addr_t s, input desc_addr_t d, input desc_num_t l, input bit la);
    wr = 1'b1; src = s; dst = d; len = l; lst = la;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_full"},  full_o,  0);
    check({tag, "_busy"},  busy_o,  0);
    check({tag, "_irq"},   irq_o,   0);
    check({tag, "_drop"},  drop_o,  0);
    check({tag, "_src"},   src_o,   0);
  endtask

  initial begin
    wr = 0; lst = 0; clr = 0; rdy = 0; done = 0; err = 0;
    src = '0; dst = '0; len = '0;
    model_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #11 rstn = 1'b1;
    check_all_zero("reset");
    chk_en = 1'b1;

    // Single last descriptor: offered, accepted, completed -> irq.
    push(32'h1000, 32'h2000, 16'd64, 1'b1); tick();
    check("t1_valid", valid_o, 1);
    check("t1_src",   src_o,   32'h1000);
    check("t1_dst",   dst_o,   32'h2000);
    check("t1_len",   len_o,   64);
    check("t1_last",  last_o,  1);
    rdy = 1; tick();
    check("t1_busy",  busy_o,  1);
    check("t1_vlow",  valid_o, 0);
    rdy = 0; done = 1; tick();
    check("t1_irq",   irq_o,   1);
    check("t1_idle",  busy_o,  0);
    clr = 1; tick();
    check("t1_clr",   irq_o,   0);

    // Fill to DEPTH, then overflow push is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h100 + i, 32'h200 + i, 16'(i + 1), 1'b0); tick();
      if (i == DEPTH - 2) check("t2_not_full", full_o, 0);
    end
    check("t2_full", full_o, 1);
    push(32'hdead, 32'hbeef, 16'd9, 1'b1); tick();
    check("t2_drop",  drop_o, 1);
    check("t2_full2", full_o, 1);
    check("t2_head",  src_o,  32'h100);
    tick();
    check("t2_drop_pulse", drop_o, 0);

    // Full + pop + push in the same cycle: push dropped, full clears.
    rdy = 1; push(32'hbeef, 32'hbeef, 16'd1, 1'b1); tick();
    check("t3_drop", drop_o, 1);
    check("t3_full", full_o, 0);
    check("t3_busy", busy_o, 1);
    rdy = 0; done = 1; tick();
    check("t3_head", src_o, 32'h101);
    for (int i = 0; i < DEPTH - 1; i++) begin
      rdy = 1; tick();
      rdy = 0; done = 1; tick();
    end
    check("t3_empty", valid_o, 0);
    check("t3_noirq", irq_o,   0);

    // Scatter list of three, last only on the third.
    for (int i = 0; i < 3; i++) begin
      push(32'h3000 + i, 32'h4000 + i, 16'd16, i == 2); tick();
    end
    for (int k = 0; k < 3; k++) begin
      rdy = 1; tick();
      rdy = 0; done = 1; tick();
      check("t4_irq", irq_o, k == 2);
    end
    clr = 1; tick();
    check("t4_clr", irq_o, 0);

    // Error while busy flushes the queue and drops the coincident push.
    for (int i = 0; i < 4; i++) begin
      push(32'h5000 + i, 32'h6000 + i, 16'd8, 1'b0); tick();
    end
    rdy = 1; tick();
    rdy = 0; err = 1; push(32'h5555, 32'h6666, 16'd4, 1'b1); tick();
    check("t5_valid", valid_o, 0);
    check("t5_full",  full_o,  0);
    check("t5_irq",   irq_o,   1);
    check("t5_drop",  drop_o,  1);
    check("t5_busy",  busy_o,  0);
    done = 1; tick();
    check("t5_done_ignored", busy_o, 0);
    check("t5_irq_held",     irq_o,  1);
    check("t5_still_empty",  valid_o, 0);
    clr = 1; tick();

    // Clear coincident with last-done: set wins.
    push(32'h7000, 32'h8000, 16'd2, 1'b1); tick();
    rdy = 1; tick();
    rdy = 0; done = 1; clr = 1; tick();
    check("t6_set_wins", irq_o, 1);
    clr = 1; tick();
    check("t6_clr", irq_o, 0);

    // Asynchronous reset while a descriptor is in flight.
    push(32'h9000, 32'h9100, 16'd3, 1'b1); tick();
    push(32'h9001, 32'h9101, 16'd3, 1'b0); tick();
    rdy = 1; tick();
    rdy = 0;
    check("t7_busy_before", busy_o, 1);
    #2 rstn = 1'b0;
    #1 check_all_zero("t7_rst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1 check("t7_post_valid", valid_o, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rdy  = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 2) != 0);
      lst  = ($urandom_range(0, 3) == 0);
      src  = $urandom;
      dst  = $urandom;
      len  = 16'($urandom);
      done = ($urandom_range(0, 3) == 0);
      err  = ($urandom_range(0, 79) == 0);
      clr  = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
